// File: rtl/tensor_cpu_pkg.sv
// Shared definitions for the sequenced tensor CPU: opcodes, instruction
// field positions and the controller state encoding.
package tensor_cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_LOADI  = 8'h03;
  localparam logic [7:0] OP_MATMUL = 8'h05;
  localparam logic [7:0] OP_TWRITE = 8'h06;
  localparam logic [7:0] OP_TREAD  = 8'h07;

  localparam int F_DST_MSB  = 31;
  localparam int F_DST_LSB  = 24;
  localparam int F_SRC1_MSB = 23;
  localparam int F_SRC1_LSB = 16;
  localparam int F_SRC2_MSB = 15;
  localparam int F_SRC2_LSB = 8;
  localparam int F_OP_MSB   = 7;
  localparam int F_OP_LSB   = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MATMUL = 1'b1
  } state_t;

endpackage

// File: rtl/tensor_cpu_sequenced_row_mac.sv
// Combinational row multiplier: one row of A times all of B gives one row
// of C. Each element is a D-term dot product truncated to DATA_WIDTH.
module tensor_row_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 4
) (
  input  logic [MATRIX_DIM*DATA_WIDTH-1:0]            i_a_row,
  input  logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0] i_b_mat,
  output logic [MATRIX_DIM*DATA_WIDTH-1:0]            o_c_row
);

  logic [DATA_WIDTH-1:0] w_acc;

  // Dot product of the A row with each B column, wrapping in DATA_WIDTH bits.
  always_comb begin
    o_c_row = '0;
    w_acc   = '0;
    for (int j = 0; j < MATRIX_DIM; j++) begin
      w_acc = '0;
      for (int k = 0; k < MATRIX_DIM; k++) begin
        w_acc = w_acc + i_a_row[k*DATA_WIDTH +: DATA_WIDTH] *
                        i_b_mat[(k*MATRIX_DIM + j)*DATA_WIDTH +: DATA_WIDTH];
      end
      o_c_row[j*DATA_WIDTH +: DATA_WIDTH] = w_acc;
    end
  end

endmodule

// File: rtl/tensor_cpu_sequenced.sv
// Sequenced tensor CPU: scalar ALU over a register file plus a three-bank
// tensor file (A, B, C). MATMUL computes C = A x B one row per cycle while
// the instruction handshake is held off.
module tensor_cpu_sequenced
  import tensor_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  input  logic [31:0]           instruction_in,
  output logic [DATA_WIDTH-1:0] cpu_output,
  output logic                  cpu_output_valid_out,
  output logic                  busy_out,
  output logic                  matmul_done_out,
  output logic                  illegal_op_out
);

  localparam int DD     = MATRIX_DIM * MATRIX_DIM;
  localparam int TSIZE  = 3 * DD;
  localparam int B_BASE = DD;
  localparam int C_BASE = 2 * DD;
  localparam int TIDX_W = (TSIZE > 1) ? $clog2(TSIZE) : 1;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int ROW_W  = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;

  // Register index from an 8-bit field; NUM_REGS is a power of two, so the
  // modulo reduces to keeping the low bits.
  function automatic logic [RIDX_W-1:0] reg_index(input logic [7:0] f);
    return RIDX_W'({1'b0, f} % 9'(NUM_REGS));
  endfunction

  // True when an 8-bit tensor address falls inside A, B or C.
  function automatic logic tensor_in_range(input logic [7:0] f);
    return ({1'b0, f} < 9'(TSIZE));
  endfunction

  state_t                          r_state;
  state_t                          w_next_state;
  logic [DATA_WIDTH-1:0]           r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]           r_tens [TSIZE];
  logic [ROW_W-1:0]                r_row;
  logic [DATA_WIDTH-1:0]           r_out;
  logic                            r_out_vld;
  logic                            r_done;
  logic                            r_illegal;

  logic                            w_ready;
  logic                            w_accept;
  logic                            w_row_last;
  logic [7:0]                      w_op;
  logic [7:0]                      w_dst_f;
  logic [7:0]                      w_s1_f;
  logic [7:0]                      w_s2_f;
  logic [RIDX_W-1:0]               w_dst;
  logic [RIDX_W-1:0]               w_s1;
  logic [RIDX_W-1:0]               w_s2;
  logic                            w_dst_t_ok;
  logic                            w_s1_t_ok;
  logic [TIDX_W-1:0]               w_dst_tidx;
  logic [TIDX_W-1:0]               w_s1_tidx;
  logic [DATA_WIDTH-1:0]           w_imm;
  logic [DATA_WIDTH-1:0]           w_add;
  logic [DATA_WIDTH-1:0]           w_sub;
  logic [DATA_WIDTH-1:0]           w_tread;
  logic [MATRIX_DIM*DATA_WIDTH-1:0] w_a_row;
  logic [MATRIX_DIM*DATA_WIDTH-1:0] w_c_row;
  logic [DD*DATA_WIDTH-1:0]        w_b_mat;

  assign w_op       = instruction_in[F_OP_MSB:F_OP_LSB];
  assign w_dst_f    = instruction_in[F_DST_MSB:F_DST_LSB];
  assign w_s1_f     = instruction_in[F_SRC1_MSB:F_SRC1_LSB];
  assign w_s2_f     = instruction_in[F_SRC2_MSB:F_SRC2_LSB];
  assign w_dst      = reg_index(w_dst_f);
  assign w_s1       = reg_index(w_s1_f);
  assign w_s2       = reg_index(w_s2_f);
  assign w_dst_t_ok = tensor_in_range(w_dst_f);
  assign w_s1_t_ok  = tensor_in_range(w_s1_f);
  assign w_dst_tidx = TIDX_W'(w_dst_f);
  assign w_s1_tidx  = TIDX_W'(w_s1_f);
  assign w_imm      = DATA_WIDTH'(w_s1_f);
  assign w_add      = r_regs[w_s1] + r_regs[w_s2];
  assign w_sub      = r_regs[w_s1] - r_regs[w_s2];
  // Out-of-range TREAD still returns a value: zero.
  assign w_tread    = w_s1_t_ok ? r_tens[w_s1_tidx] : '0;
  assign w_accept   = instr_valid_in && w_ready;
  assign w_row_last = (r_row == ROW_W'(MATRIX_DIM - 1));

  assign instr_ready_out      = w_ready;
  assign busy_out             = (r_state == ST_MATMUL);
  assign cpu_output           = r_out;
  assign cpu_output_valid_out = r_out_vld;
  assign matmul_done_out      = r_done;
  assign illegal_op_out       = r_illegal;

  // Controller state register.
  always_ff @(posedge clock_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and handshake: ready only while idle; leave MATMUL after the last row.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (instr_valid_in && (w_op == OP_MATMUL)) w_next_state = ST_MATMUL;
      end
      ST_MATMUL: begin
        if (w_row_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Present the current A row and the whole of B to the row multiplier.
  always_comb begin
    w_a_row = '0;
    w_b_mat = '0;
    for (int j = 0; j < MATRIX_DIM; j++) begin
      w_a_row[j*DATA_WIDTH +: DATA_WIDTH] = r_tens[TIDX_W'(int'(r_row)*MATRIX_DIM + j)];
    end
    for (int k = 0; k < DD; k++) begin
      w_b_mat[k*DATA_WIDTH +: DATA_WIDTH] = r_tens[TIDX_W'(B_BASE + k)];
    end
  end

  tensor_row_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_DIM (MATRIX_DIM)
  ) u_row_mac (
    .i_a_row (w_a_row),
    .i_b_mat (w_b_mat),
    .o_c_row (w_c_row)
  );

  // Register files, row counter and result pulses; reset clears everything,
  // which also aborts a multiply in flight without a done pulse.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      for (int t = 0; t < TSIZE; t++)    r_tens[t] <= '0;
      r_row     <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (r_state == ST_MATMUL) begin
        for (int j = 0; j < MATRIX_DIM; j++) begin
          r_tens[TIDX_W'(C_BASE + int'(r_row)*MATRIX_DIM + j)] <=
            w_c_row[j*DATA_WIDTH +: DATA_WIDTH];
        end
        if (w_row_last) r_done <= 1'b1;
        else            r_row  <= r_row + ROW_W'(1);
      end else if (w_accept) begin
        case (w_op)
          OP_NOP: ;
          OP_ADD: begin
            r_regs[w_dst] <= w_add;
            r_out         <= w_add;
            r_out_vld     <= 1'b1;
          end
          OP_SUB: begin
            r_regs[w_dst] <= w_sub;
            r_out         <= w_sub;
            r_out_vld     <= 1'b1;
          end
          OP_LOADI: begin
            r_regs[w_dst] <= w_imm;
            r_out         <= w_imm;
            r_out_vld     <= 1'b1;
          end
          OP_MATMUL: r_row <= '0;
          OP_TWRITE: begin
            if (w_dst_t_ok) r_tens[w_dst_tidx] <= w_imm;
            else            r_illegal          <= 1'b1;
          end
          OP_TREAD: begin
            r_regs[w_s2] <= w_tread;
            r_out        <= w_tread;
            r_out_vld    <= 1'b1;
            if (!w_s1_t_ok) r_illegal <= 1'b1;
          end
          default: r_illegal <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tensor_cpu_sequenced.sv
// Self-checking bench for tensor_cpu_sequenced: directed steps followed by
// random instructions, all compared against a behavioural model.
module tb_tensor_cpu_sequenced;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int NR  = 16;
  localparam int DD  = D * D;
  localparam int TS  = 3 * DD;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld = 1'b0;
  logic [31:0]  instr = '0;
  logic         instr_ready_out;
  logic [W-1:0] cpu_output;
  logic         cpu_output_valid_out;
  logic         busy_out;
  logic         matmul_done_out;
  logic         illegal_op_out;

  always #5 clk = ~clk;

  tensor_cpu_sequenced #(
    .DATA_WIDTH (W),
    .MATRIX_DIM (D),
    .NUM_REGS   (NR)
  ) dut (
    .clock_in             (clk),
    .reset_in             (rst),
    .instr_valid_in       (vld),
    .instr_ready_out      (instr_ready_out),
    .instruction_in       (instr),
    .cpu_output           (cpu_output),
    .cpu_output_valid_out (cpu_output_valid_out),
    .busy_out             (busy_out),
    .matmul_done_out      (matmul_done_out),
    .illegal_op_out       (illegal_op_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned m_reg [NR];
  int unsigned m_ten [TS];
  int unsigned m_out;

  function automatic logic [31:0] mk(input int dst, input int s1, input int s2, input int op);
    return {8'(dst), 8'(s1), 8'(s2), 8'(op)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    for (int t = 0; t < TS; t++) m_ten[t] = 0;
    m_out = 0;
  endfunction

  // Behavioural effect of one accepted instruction.
  function automatic void model_exec(input logic [31:0] ins, output bit ev, output bit ei);
    int op, fd, f1, f2, v;
    op = int'(ins[7:0]);
    fd = int'(ins[31:24]);
    f1 = int'(ins[23:16]);
    f2 = int'(ins[15:8]);
    ev = 0;
    ei = 0;
    case (op)
      0: ;
      1: begin
        m_out = (m_reg[f1 % NR] + m_reg[f2 % NR]) % MOD;
        m_reg[fd % NR] = m_out; ev = 1;
      end
      2: begin
        m_out = (m_reg[f1 % NR] + MOD - m_reg[f2 % NR]) % MOD;
        m_reg[fd % NR] = m_out; ev = 1;
      end
      3: begin
        m_out = f1 % MOD;
        m_reg[fd % NR] = m_out; ev = 1;
      end
      5: begin
        for (int i = 0; i < D; i++)
          for (int j = 0; j < D; j++) begin
            int unsigned s = 0;
            for (int k = 0; k < D; k++) s += m_ten[i*D + k] * m_ten[DD + k*D + j];
            m_ten[2*DD + i*D + j] = s % MOD;
          end
      end
      6: begin
        if (fd < TS) m_ten[fd] = f1 % MOD;
        else ei = 1;
      end
      7: begin
        if (f1 < TS) v = m_ten[f1];
        else begin v = 0; ei = 1; end
        m_out = v;
        m_reg[f2 % NR] = v; ev = 1;
      end
      default: ei = 1;
    endcase
  endfunction

  // Present one instruction, wait (bounded) for acceptance, check its effect.
  task automatic exec_instr(input logic [31:0] ins);
    bit ev, ei;
    int waits, low;
    @(negedge clk);
    vld = 1'b1;
    instr = ins;
    waits = 0;
    while (instr_ready_out !== 1'b1 && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    check("accept_wait", instr_ready_out, 1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    model_exec(ins, ev, ei);
    if (ins[7:0] == 8'h05) begin
      check("mm_busy", busy_out, 1);
      check("mm_ready_low", instr_ready_out, 0);
      low = 0;
      while (instr_ready_out !== 1'b1 && low < 64) begin
        check("mm_early_done", matmul_done_out, 0);
        @(posedge clk);
        #1;
        low++;
      end
      check("mm_stall_cycles", low, D);
      check("mm_done", matmul_done_out, 1);
      check("mm_busy_clear", busy_out, 0);
    end else begin
      check("out_valid", cpu_output_valid_out, ev);
      check("out_data", cpu_output, m_out);
      check("illegal", illegal_op_out, ei);
      check("ready_after", instr_ready_out, 1);
      check("no_done", matmul_done_out, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", cpu_output, 0);
    check("rst_valid", cpu_output_valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", matmul_done_out, 0);
    check("rst_illegal", illegal_op_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", instr_ready_out, 1);

    // Scalar wrap-around
    exec_instr(mk(1, 5, 0, 3));
    exec_instr(mk(2, 250, 0, 3));
    exec_instr(mk(3, 1, 2, 1));
    check("add_255", cpu_output, 255);
    exec_instr(mk(4, 3, 1, 1));
    check("add_wrap_4", cpu_output, 4);
    exec_instr(mk(5, 1, 2, 2));
    check("sub_wrap_11", cpu_output, 11);

    // Identity multiply
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        exec_instr(mk(i*D + j, (i == j) ? 1 : 0, 0, 6));
        exec_instr(mk(DD + i*D + j, 4*i + j, 0, 6));
      end
    exec_instr(mk(0, 0, 0, 5));
    for (int a = 0; a < DD; a++) begin
      exec_instr(mk(0, 2*DD + a, a % NR, 7));
      check("ident_c", cpu_output, a);
    end

    // Accumulation wrap
    for (int a = 0; a < DD; a++) begin
      exec_instr(mk(a, 2, 0, 6));
      exec_instr(mk(DD + a, 100, 0, 6));
    end
    exec_instr(mk(0, 0, 0, 5));
    exec_instr(mk(0, 2*DD, 9, 7));
    check("acc_wrap_32", cpu_output, 32);

    // Stall handling: ADD held valid through the multiply
    exec_instr(mk(6, 3, 0, 3));
    begin
      bit ev, ei;
      @(negedge clk);
      vld = 1'b1;
      instr = mk(0, 0, 0, 5);
      @(posedge clk);
      #1;
      model_exec(instr, ev, ei);
      instr = mk(6, 6, 6, 1);
      repeat (D - 1) @(posedge clk);
      @(posedge clk);
      #1;
      check("stall_done", matmul_done_out, 1);
      check("stall_ready", instr_ready_out, 1);
      check("stall_no_valid", cpu_output_valid_out, 0);
      @(posedge clk);
      #1;
      vld = 1'b0;
      model_exec(instr, ev, ei);
      check("stall_add_valid", cpu_output_valid_out, 1);
      check("stall_add_data", cpu_output, 6);
      check("stall_done_gone", matmul_done_out, 0);
      @(posedge clk);
      #1;
      check("stall_single_pulse", cpu_output_valid_out, 0);
    end
    exec_instr(mk(7, 6, 6, 1));
    check("stall_once", cpu_output, 12);

    // Reset abort while row 2 is pending
    @(negedge clk);
    vld = 1'b1;
    instr = mk(0, 0, 0, 5);
    @(posedge clk);
    #1;
    vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("abort_ready", instr_ready_out, 1);
    check("abort_busy", busy_out, 0);
    check("abort_done", matmul_done_out, 0);
    for (int c = 0; c < D + 1; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", matmul_done_out, 0);
    end
    exec_instr(mk(0, 2*DD, 1, 7));
    check("abort_c_zero", cpu_output, 0);

    // Illegal operations
    exec_instr(mk(3, 9, 0, 3));
    exec_instr(mk(3, 1, 2, 8'hFF));
    check("illegal_ff_out", cpu_output, 9);
    exec_instr(mk(4, 3, 3, 1));
    check("illegal_regs_kept", cpu_output, 18);
    exec_instr(mk(5, 77, 0, 6));
    exec_instr(mk(TS, 55, 0, 6));
    exec_instr(mk(0, 5, 2, 7));
    check("illegal_tensor_kept", cpu_output, 77);
    exec_instr(mk(0, TS, 2, 7));

    // Random instruction mix
    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [31:0] ins;
      sel = $urandom_range(0, 9);
      case (sel)
        0: ins = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1);
        1: ins = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 2);
        2: ins = mk($urandom_range(0, 255), $urandom_range(0, 255), 0, 3);
        3, 4: ins = mk($urandom_range(0, TS + 7), $urandom_range(0, 255), 0, 6);
        5, 6: ins = mk(0, $urandom_range(0, TS + 7), $urandom_range(0, 255), 7);
        7: ins = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
        8: ins = mk(1, 2, 3, (($urandom_range(0, 1) == 0) ? 4 : $urandom_range(8, 255)));
        default: ins = mk(0, 0, 0, 5);
      endcase
      exec_instr(ins);
    end

    // Sweep the tensor file through the model
    for (int a = 0; a < TS; a++) exec_instr(mk(0, a, a % NR, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
